// File: rtl/aes_pkg.sv
// Shared constants and FSM encoding for the AES core arbiter.
package aes_pkg;

  localparam int AES_BLOCK_W  = 128;

  localparam int KEY_SIZE_128 = 128;
  localparam int KEY_SIZE_192 = 192;
  localparam int KEY_SIZE_256 = 256;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester above last_grant wins,
// wrapping to the lowest index when nothing above it is requesting.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_valid
);

  // NOTE: every output of an always_comb block is given a default before any
  // branch, so no path through the block can leave it unassigned and infer a latch.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    // Upper segment first (strictly above last_grant), then the wrapped lower one.
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_valid && req[k] && (k > int'(last_grant))) begin
        grant[k]    = 1'b1;
        grant_idx   = ID_W'(k);
        grant_valid = 1'b1;
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_valid && req[k] && (k <= int'(last_grant))) begin
        grant[k]    = 1'b1;
        grant_idx   = ID_W'(k);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/aes_core_arbiter.sv
// Round-robin scheduler sharing one external AESCore among NUM_REQ requesters.
// Define AES_ARB_TIMEOUT_EN to build the watchdog that aborts a hung core.
module aes_core_arbiter
  import aes_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int KEY_SIZE       = KEY_SIZE_128,
  parameter int ID_W           = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                            iClk,
  input  logic                            iRst,
  input  logic [NUM_REQ-1:0]              iReqValid,
  input  logic [NUM_REQ*AES_BLOCK_W-1:0]  iReqPlaintext,
  input  logic [NUM_REQ*KEY_SIZE-1:0]     iReqKey,
  output logic [NUM_REQ-1:0]              oReqReady,
  output logic                            oRspValid,
  output logic [ID_W-1:0]                 oRspId,
  output logic [AES_BLOCK_W-1:0]          oRspCiphertext,
  output logic                            oRspError,
  input  logic                            iRspReady,
  output logic                            oCoreStart,
  output logic [AES_BLOCK_W-1:0]          oCorePlaintext,
  output logic [KEY_SIZE-1:0]             oCoreKey,
  input  logic [AES_BLOCK_W-1:0]          iCoreCiphertext,
  input  logic                            iCoreDone
);

  arb_state_e             state;
  arb_state_e             state_next;
  logic [ID_W-1:0]        last_grant;
  logic [ID_W-1:0]        cur_id;
  logic [AES_BLOCK_W-1:0] pt_hold;
  logic [KEY_SIZE-1:0]    key_hold;
  logic [AES_BLOCK_W-1:0] rsp_ct;
  logic [AES_BLOCK_W-1:0] sel_pt;
  logic [KEY_SIZE-1:0]    sel_key;
  logic [NUM_REQ-1:0]     grant;
  logic [ID_W-1:0]        grant_idx;
  logic                   grant_valid;
  logic                   accept;
  logic                   timeout;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req         (iReqValid),
    .last_grant  (last_grant),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Ready doubles as the accept strobe, so it must stay low while reset wins the edge.
  assign accept = (state == ST_IDLE) && grant_valid && !iRst;

  always_comb begin
    sel_pt  = '0;
    sel_key = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        sel_pt  = iReqPlaintext[k*AES_BLOCK_W +: AES_BLOCK_W];
        sel_key = iReqKey[k*KEY_SIZE +: KEY_SIZE];
      end
    end
  end

  // NOTE: registers are written with non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge iClk) begin
    if (iRst) state <= ST_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (grant_valid)           state_next = ST_ISSUE;
      ST_ISSUE:                            state_next = ST_WAIT;
      ST_WAIT:  if (iCoreDone || timeout)  state_next = ST_RESP;
      ST_RESP:  if (iRspReady)             state_next = ST_IDLE;
      default:                             state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      last_grant <= ID_W'(NUM_REQ - 1);
      cur_id     <= '0;
      pt_hold    <= '0;
      key_hold   <= '0;
      rsp_ct     <= '0;
    end else begin
      if (accept) begin
        last_grant <= grant_idx;
        cur_id     <= grant_idx;
        pt_hold    <= sel_pt;
        key_hold   <= sel_key;
      end
      if (state == ST_WAIT) begin
        if (iCoreDone)    rsp_ct <= iCoreCiphertext;
        else if (timeout) rsp_ct <= '0;
      end
    end
  end

`ifdef AES_ARB_TIMEOUT_EN
  localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic [31:0] wd_cnt;
  logic        rsp_err;

  // wd_cnt holds the number of WAIT cycles already completed.
  assign timeout = (state == ST_WAIT) && !iCoreDone && (wd_cnt == WD_LAST);

  always_ff @(posedge iClk) begin
    if (iRst) begin
      wd_cnt  <= '0;
      rsp_err <= 1'b0;
    end else begin
      if (state == ST_ISSUE) begin
        wd_cnt  <= '0;
        rsp_err <= 1'b0;
      end else if (state == ST_WAIT) begin
        wd_cnt <= wd_cnt + 32'd1;
        if (timeout) rsp_err <= 1'b1;
      end
    end
  end

  assign oRspError = rsp_err;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
  assign timeout   = 1'b0;
  assign oRspError = 1'b0;
`endif

  assign oReqReady      = {NUM_REQ{accept}} & grant;
  assign oCoreStart     = (state == ST_ISSUE);
  assign oRspValid      = (state == ST_RESP);
  assign oRspId         = cur_id;
  assign oRspCiphertext = rsp_ct;
  assign oCorePlaintext = pt_hold;
  assign oCoreKey       = key_hold;

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Self-checking bench for aes_core_arbiter with a behavioural AESCore stand-in.
// The timeout sequence is compiled in when AES_ARB_TIMEOUT_EN is defined.
module tb_aes_core_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int KEY_SIZE = 128;
  localparam int ID_W     = 2;
  localparam int TO       = 16;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic                         clk = 1'b0;
  logic                         rst = 1'b1;
  logic [NUM_REQ-1:0]           req_valid = '0;
  logic [127:0]                 req_pt  [NUM_REQ];
  logic [KEY_SIZE-1:0]          req_key [NUM_REQ];
  logic [NUM_REQ*128-1:0]       pt_bus;
  logic [NUM_REQ*KEY_SIZE-1:0]  key_bus;
  logic                         rsp_ready = 1'b0;

  logic [NUM_REQ-1:0]  oReqReady;
  logic                oRspValid;
  logic [ID_W-1:0]     oRspId;
  logic [127:0]        oRspCiphertext;
  logic                oRspError;
  logic                oCoreStart;
  logic [127:0]        oCorePlaintext;
  logic [KEY_SIZE-1:0] oCoreKey;
  logic [127:0]        core_ct;
  logic                core_done;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  always_comb begin
    pt_bus  = '0;
    key_bus = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pt_bus[k*128 +: 128]           = req_pt[k];
      key_bus[k*KEY_SIZE +: KEY_SIZE] = req_key[k];
    end
  end

  aes_core_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .KEY_SIZE       (KEY_SIZE),
    .ID_W           (ID_W),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .iClk            (clk),
    .iRst            (rst),
    .iReqValid       (req_valid),
    .iReqPlaintext   (pt_bus),
    .iReqKey         (key_bus),
    .oReqReady       (oReqReady),
    .oRspValid       (oRspValid),
    .oRspId          (oRspId),
    .oRspCiphertext  (oRspCiphertext),
    .oRspError       (oRspError),
    .iRspReady       (rsp_ready),
    .oCoreStart      (oCoreStart),
    .oCorePlaintext  (oCorePlaintext),
    .oCoreKey        (oCoreKey),
    .iCoreCiphertext (core_ct),
    .iCoreDone       (core_done)
  );

  // Stand-in cipher: the real AES only for the FIPS-197 vector, a cheap mix otherwise.
  function automatic logic [127:0] aes_model(input logic [127:0] pt, input logic [127:0] key);
    if (pt == FIPS_PT && key == FIPS_KEY) return FIPS_CT;
    return {pt[63:0], pt[127:64]} ^ key ^ 128'h5a5a_3c3c_0f0f_a5a5_c3c3_f0f0_1234_5678;
  endfunction

  // Core model: done is high during cycle start+core_lat, ciphertext is junk otherwise.
  int           core_lat  = 5;
  bit           core_mute = 1'b0;
  bit           spur_done = 1'b0;
  int           core_cnt  = 0;
  logic [127:0] core_pt   = '0;
  logic [127:0] core_key  = '0;

  always @(posedge clk) begin
    if (rst) core_cnt <= 0;
    else if (oCoreStart) begin
      core_cnt <= core_lat;
      core_pt  <= oCorePlaintext;
      core_key <= oCoreKey;
    end else if (core_cnt != 0) core_cnt <= core_cnt - 1;
  end

  assign core_done = ((core_cnt == 1) && !core_mute) || spur_done;
  assign core_ct   = core_done ? aes_model(core_pt, core_key) : 128'hdead_beef_dead_beef_dead_beef_dead_beef;

  // Reference round-robin rule: first valid index after last, wrapping.
  function automatic int rr_pick(input logic [NUM_REQ-1:0] mask, input int last);
    for (int d = 1; d <= NUM_REQ; d++)
      if (mask[(last + d) % NUM_REQ]) return (last + d) % NUM_REQ;
    return -1;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input int i);
    return NUM_REQ'(1) << i;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic randomize_data();
    for (int k = 0; k < NUM_REQ; k++) begin
      req_pt[k]  = {$urandom, $urandom, $urandom, $urandom};
      req_key[k] = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  // Called at a negedge in IDLE; returns at a negedge back in IDLE.
  task automatic run_txn(input logic [NUM_REQ-1:0] mask, input int exp_id, input int rdy_delay,
                         input int exp_lat, input bit exp_err, output logic [127:0] got_ct);
    logic [127:0] exp_ct;
    int cyc;
    int starts;
    exp_ct = exp_err ? '0 : aes_model(req_pt[exp_id], req_key[exp_id]);
    req_valid = mask;
    #1;
    check("accept_ready", oReqReady, onehot(exp_id));
    @(negedge clk);
    req_valid = '0;
    check("start_pulse", oCoreStart, 1);
    check("core_pt", oCorePlaintext, req_pt[exp_id]);
    check("core_key", oCoreKey, req_key[exp_id]);
    starts = oCoreStart ? 1 : 0;
    cyc = 1;
    while (!oRspValid && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (oCoreStart) starts++;
    end
    check("rsp_latency", cyc, exp_lat);
    check("start_count", starts, 1);
    check("rsp_id", oRspId, exp_id);
    check("rsp_ct", oRspCiphertext, exp_ct);
    check("rsp_err", oRspError, exp_err);
    got_ct = oRspCiphertext;
    repeat (rdy_delay) @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_released", oRspValid, 0);
  endtask

  task automatic drain_rsp(input int exp_id, input string name);
    int cyc;
    cyc = 0;
    while (!oRspValid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check({name, "_valid"}, oRspValid, 1);
    check({name, "_id"}, oRspId, exp_id);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic [NUM_REQ-1:0] mask;
    int                 exp_id;
    int                 rdy_delay;
  } vec_t;

  vec_t tbl [9];

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] got;
    int           got_ids [5];
    int           n, cyc, exp, nxt, bad;
    logic [ID_W-1:0] hold_id;
    logic [127:0]    hold_ct;
    logic [NUM_REQ-1:0] mask;
    int              last_model;

    // Expected grants derived by hand from the rotation rule, starting after the FIPS grant (last = 2).
    tbl[0] = '{4'b1111, 3, 0};
    tbl[1] = '{4'b1111, 0, 2};
    tbl[2] = '{4'b0101, 2, 0};
    tbl[3] = '{4'b0011, 0, 1};
    tbl[4] = '{4'b1000, 3, 0};
    tbl[5] = '{4'b0110, 1, 3};
    tbl[6] = '{4'b0001, 0, 0};
    tbl[7] = '{4'b1001, 3, 1};
    tbl[8] = '{4'b0110, 1, 0};

    randomize_data();

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req_ready", oReqReady, 0);
    check("rst_rsp_valid", oRspValid, 0);
    check("rst_rsp_id", oRspId, 0);
    check("rst_rsp_ct", oRspCiphertext, 0);
    check("rst_rsp_err", oRspError, 0);
    check("rst_core_start", oCoreStart, 0);
    check("rst_core_pt", oCorePlaintext, 0);
    check("rst_core_key", oCoreKey, 0);
    req_valid = '1;
    #1;
    check("rst_ready_gated", oReqReady, 0);

    // Round-robin with everybody valid from reset and the consumer always ready
    @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b1;
    n = 0;
    cyc = 0;
    for (int i = 0; i < 5; i++) got_ids[i] = -1;
    while (n < 5 && cyc < 300) begin
      #1;
      if (oReqReady != 0) begin
        got_ids[n] = ($countones(oReqReady) == 1) ? $clog2(int'(oReqReady)) : -2;
        n++;
      end
      @(negedge clk);
      cyc++;
    end
    for (int i = 0; i < 5; i++) check("rr_order", got_ids[i], i % NUM_REQ);
    req_valid = '0;
    rsp_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // FIPS-197 vector through requester 2
    req_pt[2]  = FIPS_PT;
    req_key[2] = FIPS_KEY;
    run_txn(4'b0100, 2, 1, 2 + core_lat, 1'b0, got);
    check("fips_ct", got, FIPS_CT);

    // Table-driven grant sequence
    for (int i = 0; i < 9; i++) begin
      randomize_data();
      run_txn(tbl[i].mask, tbl[i].exp_id, tbl[i].rdy_delay, 2 + core_lat, 1'b0, got);
    end
    last_model = tbl[8].exp_id;

    // Backpressure: response stalls 20 cycles while other requesters wait
    randomize_data();
    exp = rr_pick('1, last_model);
    last_model = exp;
    req_valid = '1;
    #1;
    check("bp_ready", oReqReady, onehot(exp));
    @(negedge clk);
    req_valid[exp] = 1'b0;
    cyc = 0;
    while (!oRspValid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("bp_valid", oRspValid, 1);
    hold_id = oRspId;
    hold_ct = oRspCiphertext;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      #1;
      if (!oRspValid || oRspId != hold_id || oRspCiphertext != hold_ct || oReqReady != 0 || oCoreStart)
        bad++;
    end
    check("bp_hold_stable", bad, 0);
    check("bp_id", hold_id, exp);
    check("bp_ct", hold_ct, aes_model(req_pt[exp], req_key[exp]));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    check("bp_handshake", oRspValid, 0);
    nxt = rr_pick(req_valid, last_model);
    last_model = nxt;
    check("bp_next_accept", oReqReady, onehot(nxt));
    @(negedge clk);
    req_valid = '0;
    drain_rsp(nxt, "bp_next");

    // Reset during WAIT with a spurious done in the same cycle
    mask = 4'b1000;
    exp = rr_pick(mask, last_model);
    req_valid = mask;
    #1;
    check("rm_ready", oReqReady, onehot(exp));
    @(negedge clk);
    req_valid = '0;
    check("rm_start", oCoreStart, 1);
    @(negedge clk);
    rst = 1'b1;
    spur_done = 1'b1;
    req_valid = '1;
    @(negedge clk);
    spur_done = 1'b0;
    #1;
    check("rm_no_rsp", oRspValid, 0);
    check("rm_no_start", oCoreStart, 0);
    check("rm_ready_gated", oReqReady, 0);
    check("rm_pt_cleared", oCorePlaintext, 0);
    check("rm_ct_cleared", oRspCiphertext, 0);
    rst = 1'b0;
    #1;
    last_model = NUM_REQ - 1;
    exp = rr_pick('1, last_model);
    last_model = exp;
    check("rm_first_grant", oReqReady, onehot(exp));
    @(negedge clk);
    req_valid = '0;
    drain_rsp(exp, "rm_after");

`ifdef AES_ARB_TIMEOUT_EN
    // Hung core: watchdog aborts, then the next request is served normally
    core_mute = 1'b1;
    randomize_data();
    exp = rr_pick(4'b0010, last_model);
    last_model = exp;
    run_txn(4'b0010, exp, 0, 2 + TO, 1'b1, got);
    core_mute = 1'b0;
    exp = rr_pick(4'b0100, last_model);
    last_model = exp;
    run_txn(4'b0100, exp, 0, 2 + core_lat, 1'b0, got);
`endif

    // Randomized traffic against the reference rotation and cipher models
    for (int i = 0; i < 30; i++) begin
      randomize_data();
      mask = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      exp = rr_pick(mask, last_model);
      last_model = exp;
      core_lat = $urandom_range(1, 8);
      run_txn(mask, exp, $urandom_range(0, 3), 2 + core_lat, 1'b0, got);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/aes_core_arbiter.md
# aes_core_arbiter

Round-robin scheduler that shares one AESCore instance between NUM_REQ independent requesters, such as the Avalon-MM register front end, a DMA streamer and a self-test engine. It accepts one request at a time and holds plaintext and key stable into the core. It issues the single-cycle start, waits for done, then returns the ciphertext tagged with the requester ID on a valid/ready response channel. It sits between the requester ports and AESCore; AESCore is instantiated by the parent, not inside this block.

## Interface
- NUM_REQ, 4, number of requesters (2..8).
- KEY_SIZE, 128, key width; 128, 192 or 256, must match AESCore.
- ID_W, $clog2(NUM_REQ), requester ID width.
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with AES_ARB_TIMEOUT_EN.
- iClk  in  1  clock; single clock domain.
- iRst  in  1  reset, synchronous, active-high.
- iReqValid  in  NUM_REQ  per-requester request valid.
- iReqPlaintext  in  NUM_REQ*128  plaintext; requester k occupies bits [128k+127:128k].
- iReqKey  in  NUM_REQ*KEY_SIZE  key; requester k occupies bits [KEY_SIZE*k +: KEY_SIZE].
- oReqReady  out  NUM_REQ  one-hot accept strobe.
- oRspValid  out  1  response valid.
- oRspId  out  ID_W  index of the requester that is being answered.
- oRspCiphertext  out  128  ciphertext.
- oRspError  out  1  timeout abort flag; constant 0 without AES_ARB_TIMEOUT_EN.
- iRspReady  in  1  response consumer ready.
- oCoreStart  out  1  start pulse to AESCore iStart.
- oCorePlaintext  out  128  to AESCore iPlaintext.
- oCoreKey  out  KEY_SIZE  to AESCore iKey.
- iCoreCiphertext  in  128  from AESCore oCiphertext.
- iCoreDone  in  1  from AESCore oDone.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If any iReqValid is high, grant the first set bit searching upward, with wrap, from last_grant+1.
  - oReqReady[grant] is high combinationally in this cycle; this is the handshake.
  - Register the granted plaintext and key into holding registers.
  - Store grant as the current ID and update last_grant.
  - Go to ISSUE.
- **ISSUE**
  - oCoreStart = 1 for exactly this cycle.
  - Go to WAIT.
- **WAIT**
  - On iCoreDone, capture iCoreCiphertext into the response register, set oRspError = 0 and go to RESP.
- **RESP**
  - oRspValid = 1. oRspId, oRspCiphertext and oRspError are held stable.
  - When iRspReady is high, go to IDLE.
- oCorePlaintext and oCoreKey always drive the holding registers. They change only on an IDLE accept.
- oReqReady is 0 in every state except IDLE, so at most one request is outstanding.
- Requesters must hold iReqValid and their data stable until they see ready. A requester that drops valid before grant is simply not considered.
- iCoreDone is ignored outside WAIT.

## Timing
- Reset values:
  - state = IDLE.
  - last_grant = NUM_REQ-1, so requester 0 has first priority.
  - All outputs 0, including the holding and response registers.
- Latency: accept in cycle 0, oCoreStart in cycle 1, iCoreDone in cycle 1+L (L = AESCore latency), oRspValid from cycle 2+L.
- Throughput: the next accept happens at the earliest in the cycle after the response handshake.
- If iRspReady is already high when RESP is entered, the response handshake completes in that first RESP cycle.
- Fairness: with all requesters valid continuously, grants rotate 0,1,…,NUM_REQ-1,0.
- iRst in any state returns the block to IDLE on the next edge and drops every output to 0.
  - The parent ties AESCore iRst to the same reset, so no stale iCoreDone can follow.
  - A response that was in flight is discarded.

## Configuration
- **AES_ARB_TIMEOUT_EN defined**
  - A 32-bit counter clears on ISSUE and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without iCoreDone, the block enters RESP with oRspError = 1 and oRspCiphertext = 0.
  - The next request proceeds normally.
- **AES_ARB_TIMEOUT_EN undefined**
  - No counter is built and WAIT has no exit other than iCoreDone.
  - oRspError is tied to 0.

## Structure
- Package aes_pkg holds:
  - the FSM state encoding (IDLE, ISSUE, WAIT, RESP);
  - the allowed KEY_SIZE constants (128, 192, 256);
  - the AES block width constant (128).
- Sub-module rr_arbiter, parameterised by NUM_REQ:
  - inputs: request vector and last_grant;
  - outputs: one-hot grant and encoded index;
  - purely combinational.
- The FSM, holding registers and watchdog live in aes_core_arbiter.

## Test plan
- **FIPS-197 vector:** requester 2 submits key 000102030405060708090a0b0c0d0e0f and plaintext 00112233445566778899aabbccddeeff.
  - Expect oRspCiphertext = 69c4e0d86a7b0430d8cdb78070b4c55a and oRspId = 2.
  - Expect one oCoreStart pulse, 1 cycle after accept.
- **Round-robin:** all 4 requesters hold valid from reset with iRspReady tied to 1.
  - Expect grant order 0,1,2,3,0, each request accepted exactly once per lap.
- **Backpressure:** iRspReady held 0 for 20 cycles after oRspValid.
  - Expect the response to stay stable, no new oReqReady and no oCoreStart.
  - Expect the handshake on the cycle iRspReady rises.
- **Reset mid-operation:** assert iRst during WAIT, with a spurious iCoreDone in the same cycle.
  - Expect IDLE next cycle, no oRspValid, and requester 0 granted first afterwards.
- **Timeout (AES_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 16):** the core model never asserts done.
  - Expect oRspValid with oRspError = 1 after 16 WAIT cycles, then normal service of the next request.
